gpr_wb_arbiter: RTL and testbench

Shares the single write port of the multithreaded GPR register file between NSRC writeback sources, for example the ALU, load unit and FPU. Each source gets a small FIFO with a valid/ready handshake. A round-robin arbiter drains the FIFOs into a registered write-port stage that drives the regfile's byte-write enable, address and data. A combinational hazard query tells issue logic when a register read would miss a write that is still pending.

---
 rtl/gpr_wb_arbiter_pkg.sv | 24 ++
 rtl/gpr_wb_arbiter_fifo.sv | 67 ++++++
 rtl/gpr_wb_arbiter.sv | 118 +++++++++++
 tb/tb_gpr_wb_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared types and constants for the GPR writeback arbiter.
// Writes are held as {address, byte enables, data}.
package rfPhoenixPkg;

    localparam int TID_MSB = 1;
    localparam int WB_AW   = 5 + TID_MSB + 2;
    localparam int NWBSRC  = 3;

    typedef logic [31:0] value_t;

    localparam int WB_DW = $bits(value_t);

    typedef struct packed {
        logic [WB_AW-1:0] wa;
        logic [3:0]       be;
        value_t           data;
    } wb_req_t;

    // r0 is hardwired to zero, so a write to it must not touch the regfile.
    function automatic logic [3:0] wb_byte_en(wb_req_t req);
        return (req.wa[4:0] == 5'd0) ? 4'b0000 : req.be;
    endfunction

endpackage

// File: rtl/gpr_wb_arbiter_fifo.sv
// Small synchronous FIFO of writeback requests.
// Also exposes which entries are live, for the hazard compare.
module gpr_wb_fifo
    import rfPhoenixPkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              push,
    input  wb_req_t                           push_data,
    input  logic                              pop,
    output wb_req_t                           head,
    output logic                              full,
    output logic                              empty,
    output logic [DEPTH-1:0]                  ent_valid,
    output logic [DEPTH-1:0][WB_AW-1:0]       ent_wa
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count;
    logic [IW-1:0] offset;
    wb_req_t       mem [DEPTH];

    assign full  = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[IW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset; liveness comes from the pointers.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[IW-1:0]] <= push_data;
        end
    end

    // An entry is live when its distance from the read pointer is below the fill count.
    always_comb begin
        offset    = '0;
        ent_valid = '0;
        ent_wa    = '0;
        for (int e = 0; e < DEPTH; e++) begin
            offset       = IW'(e) - rd_ptr[IW-1:0];
            ent_valid[e] = ({1'b0, offset} < count);
            ent_wa[e]    = mem[e].wa;
        end
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Round-robin arbiter that shares the GPR write port between writeback sources,
// with per-source FIFOs, a registered write stage and a read-hazard query.
module gpr_wb_arbiter
    import rfPhoenixPkg::*;
#(
    parameter int NSRC  = NWBSRC,
    parameter int DEPTH = 2,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NSRC-1:0]     src_valid,
    output logic [NSRC-1:0]     src_ready,
    input  logic [NSRC*AW-1:0]  src_wa,
    input  logic [NSRC*4-1:0]   src_be,
    input  logic [NSRC*DW-1:0]  src_data,
    output logic [3:0]          rf_wr,
    output logic [AW-1:0]       rf_wa,
    output logic [DW-1:0]       rf_i,
    input  logic [AW-1:0]       chk_ra,
    output logic                chk_hazard,
    output logic                busy
);

    localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [NSRC-1:0]                    full;
    logic [NSRC-1:0]                    empty;
    logic [NSRC-1:0]                    push;
    logic [NSRC-1:0]                    pop;
    wb_req_t                            heads [NSRC];
    logic [NSRC-1:0][DEPTH-1:0]         ent_valid;
    logic [NSRC-1:0][DEPTH-1:0][AW-1:0] ent_wa;

    logic [SW-1:0] last;
    logic [SW-1:0] grant;
    logic          grant_valid;
    int            idx;
    wb_req_t       head_sel;

    // Ready depends only on stored state, never on a same-cycle pop.
    assign src_ready = ~full;
    assign push      = src_valid & ~full;

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        gpr_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[s]),
            .push_data ('{wa: src_wa[s*AW +: AW], be: src_be[s*4 +: 4], data: src_data[s*DW +: DW]}),
            .pop       (pop[s]),
            .head      (heads[s]),
            .full      (full[s]),
            .empty     (empty[s]),
            .ent_valid (ent_valid[s]),
            .ent_wa    (ent_wa[s])
        );
    end

    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        idx         = 0;
        for (int k = 1; k <= NSRC; k++) begin
            idx = (int'(last) + k) % NSRC;
            if (!grant_valid && !empty[idx]) begin
                grant_valid = 1'b1;
                grant       = SW'(idx);
            end
        end
    end

    always_comb begin
        pop = '0;
        if (grant_valid) begin
            pop[grant] = 1'b1;
        end
    end

    assign head_sel = heads[grant];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wr <= 4'b0000;
            rf_wa <= '0;
            rf_i  <= '0;
            last  <= SW'(NSRC - 1);
        end else if (grant_valid) begin
            rf_wr <= wb_byte_en(head_sel);
            rf_wa <= head_sel.wa;
            rf_i  <= head_sel.data;
            last  <= grant;
        end else begin
            rf_wr <= 4'b0000;
        end
    end

    // The write-stage term covers the regfile's one-cycle read latency.
    always_comb begin
        chk_hazard = 1'b0;
        if (chk_ra[4:0] != 5'd0) begin
            if ((rf_wr != 4'b0000) && (rf_wa == chk_ra)) begin
                chk_hazard = 1'b1;
            end
            for (int s = 0; s < NSRC; s++) begin
                for (int e = 0; e < DEPTH; e++) begin
                    if (ent_valid[s][e] && (ent_wa[s][e] == chk_ra)) begin
                        chk_hazard = 1'b1;
                    end
                end
            end
        end
    end

    assign busy = (~&empty) || (rf_wr != 4'b0000);

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed self-checking bench for gpr_wb_arbiter with a tiny regfile model
// and per-source in-order scoreboards for the saturated traffic test.
module tb_gpr_wb_arbiter;

    logic         clk;
    logic         rst_n;
    logic [2:0]   src_valid;
    logic [2:0]   src_ready;
    logic [23:0]  src_wa;
    logic [11:0]  src_be;
    logic [95:0]  src_data;
    logic [3:0]   rf_wr;
    logic [7:0]   rf_wa;
    logic [31:0]  rf_i;
    logic [7:0]   chk_ra;
    logic         chk_hazard;
    logic         busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] regmem [256];
    logic [39:0] q0 [$];
    logic [39:0] q1 [$];
    logic [39:0] q2 [$];

    gpr_wb_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_wa     (src_wa),
        .src_be     (src_be),
        .src_data   (src_data),
        .rf_wr      (rf_wr),
        .rf_wa      (rf_wa),
        .rf_i       (rf_i),
        .chk_ra     (chk_ra),
        .chk_hazard (chk_hazard),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Regfile model: byte-granular write on the rising edge.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (rf_wr[b]) begin
                regmem[rf_wa][b*8 +: 8] <= rf_i[b*8 +: 8];
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int s, input logic v, input logic [7:0] wa,
                                 input logic [3:0] be, input logic [31:0] data);
        src_valid[s]        = v;
        src_wa[s*8 +: 8]    = wa;
        src_be[s*4 +: 4]    = be;
        src_data[s*32 +: 32] = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input int s, input logic [39:0] v);
        case (s)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic retireCheck();
        int          s;
        logic [39:0] e;
        bit          ok;
        if (rf_wr != 4'b0000) begin
            s  = int'(rf_i[31:24]);
            ok = 1'b0;
            e  = '0;
            if (s == 0 && q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            if (s == 1 && q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            if (s == 2 && q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
            if (ok) checkOutput("bp_beat", {24'h0, rf_wa, rf_i}, {24'h0, e});
            else    checkOutput("bp_orphan", {24'h0, rf_wa, rf_i}, 64'h0);
            checkOutput("bp_be", {60'h0, rf_wr}, 64'hF);
        end
    endtask

    initial begin
        logic [7:0]  seq [6];
        int          n [3];
        logic [2:0]  rdy;
        bit          saw_low1;
        int          pushed;

        rst_n     = 1'b0;
        src_valid = '0;
        src_wa    = '0;
        src_be    = '0;
        src_data  = '0;
        chk_ra    = 8'h23;
        #22;
        checkOutput("rst_rf_wr", {60'h0, rf_wr}, 64'h0);
        checkOutput("rst_rf_wa", {56'h0, rf_wa}, 64'h0);
        checkOutput("rst_rf_i", {32'h0, rf_i}, 64'h0);
        checkOutput("rst_ready", {61'h0, src_ready}, 64'h7);
        checkOutput("rst_busy", {63'h0, busy}, 64'h0);
        checkOutput("rst_hazard", {63'h0, chk_hazard}, 64'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single write through an idle arbiter.
        applyStimulus(0, 1'b1, 8'h23, 4'hF, 32'hDEADBEEF);
        chk_ra = 8'h23;
        #1;
        checkOutput("t2_hz_pre", {63'h0, chk_hazard}, 64'h0);
        tick();
        applyStimulus(0, 1'b0, 8'h00, 4'h0, 32'h0);
        checkOutput("t2_hz_k", {63'h0, chk_hazard}, 64'h1);
        checkOutput("t2_wr_k", {60'h0, rf_wr}, 64'h0);
        checkOutput("t2_busy_k", {63'h0, busy}, 64'h1);
        tick();
        checkOutput("t2_wr", {60'h0, rf_wr}, 64'hF);
        checkOutput("t2_wa", {56'h0, rf_wa}, 64'h23);
        checkOutput("t2_i", {32'h0, rf_i}, 64'hDEADBEEF);
        checkOutput("t2_hz_k1", {63'h0, chk_hazard}, 64'h1);
        tick();
        checkOutput("t2_wr_done", {60'h0, rf_wr}, 64'h0);
        checkOutput("t2_hz_done", {63'h0, chk_hazard}, 64'h0);
        checkOutput("t2_wa_hold", {56'h0, rf_wa}, 64'h23);

        // Reset while beats are queued: nothing may survive.
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 1'b1, 8'h31, 4'hF, 32'h0000_1111);
            applyStimulus(1, 1'b1, 8'h32, 4'hF, 32'h0000_2222);
            tick();
        end
        applyStimulus(0, 1'b0, 8'h0, 4'h0, 32'h0);
        applyStimulus(1, 1'b0, 8'h0, 4'h0, 32'h0);
        chk_ra = 8'h32;
        rst_n  = 1'b0;
        #1;
        checkOutput("t1_wr", {60'h0, rf_wr}, 64'h0);
        checkOutput("t1_busy", {63'h0, busy}, 64'h0);
        checkOutput("t1_ready", {61'h0, src_ready}, 64'h7);
        checkOutput("t1_hazard", {63'h0, chk_hazard}, 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("t1_wr_after", {60'h0, rf_wr}, 64'h0);
        checkOutput("t1_busy_after", {63'h0, busy}, 64'h0);

        // Round-robin starts at source 0 after reset.
        seq = '{8'h01, 8'h11, 8'h21, 8'h02, 8'h12, 8'h22};
        for (int s = 0; s < 3; s++) applyStimulus(s, 1'b1, seq[s], 4'hF, 32'hA0 + s);
        tick();
        for (int s = 0; s < 3; s++) applyStimulus(s, 1'b1, seq[s+3], 4'hF, 32'hB0 + s);
        tick();
        for (int s = 0; s < 3; s++) applyStimulus(s, 1'b0, 8'h0, 4'h0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            checkOutput($sformatf("t3_wa%0d", i), {56'h0, rf_wa}, {56'h0, seq[i]});
            checkOutput($sformatf("t3_wr%0d", i), {60'h0, rf_wr}, 64'hF);
        end
        tick();
        checkOutput("t3_idle", {60'h0, rf_wr}, 64'h0);

        // Saturated traffic with per-source scoreboards.
        n        = '{0, 0, 0};
        saw_low1 = 1'b0;
        pushed   = 0;
        for (int c = 0; c < 30; c++) begin
            for (int s = 0; s < 3; s++) begin
                applyStimulus(s, 1'b1, {1'b0, 2'(s), 5'((n[s] % 31) + 1)}, 4'hF,
                              {8'(s), 24'(n[s])});
            end
            rdy = src_ready;
            if (!rdy[1]) saw_low1 = 1'b1;
            tick();
            for (int s = 0; s < 3; s++) begin
                if (rdy[s]) begin
                    pushExp(s, {1'b0, 2'(s), 5'((n[s] % 31) + 1), 8'(s), 24'(n[s])});
                    n[s]++;
                    pushed++;
                end
            end
            retireCheck();
        end
        for (int s = 0; s < 3; s++) applyStimulus(s, 1'b0, 8'h0, 4'h0, 32'h0);
        for (int c = 0; c < 20 && busy; c++) begin
            tick();
            retireCheck();
        end
        checkOutput("bp_ready1_dropped", {63'h0, saw_low1}, 64'h1);
        checkOutput("bp_drained", {63'h0, busy}, 64'h0);
        checkOutput("bp_left", 64'(q0.size() + q1.size() + q2.size()), 64'h0);
        checkOutput("bp_count", 64'(n[0] + n[1] + n[2]), 64'(pushed));

        // Write to thread 2 r0 consumes a slot but writes nothing.
        applyStimulus(2, 1'b1, 8'h40, 4'hF, 32'hCAFEF00D);
        chk_ra = 8'h40;
        tick();
        applyStimulus(2, 1'b0, 8'h0, 4'h0, 32'h0);
        checkOutput("t5_hz_q", {63'h0, chk_hazard}, 64'h0);
        checkOutput("t5_busy_q", {63'h0, busy}, 64'h1);
        tick();
        checkOutput("t5_wr", {60'h0, rf_wr}, 64'h0);
        checkOutput("t5_wa", {56'h0, rf_wa}, 64'h40);
        checkOutput("t5_i", {32'h0, rf_i}, 64'hCAFEF00D);
        checkOutput("t5_busy", {63'h0, busy}, 64'h0);

        // Partial byte write merges into the previous full-word value.
        applyStimulus(0, 1'b1, 8'h05, 4'hF, 32'hAABBCCDD);
        tick();
        applyStimulus(0, 1'b0, 8'h0, 4'h0, 32'h0);
        tick();
        tick();
        applyStimulus(0, 1'b1, 8'h05, 4'b0101, 32'h11223344);
        tick();
        applyStimulus(0, 1'b0, 8'h0, 4'h0, 32'h0);
        tick();
        checkOutput("t6_wr", {60'h0, rf_wr}, 64'h5);
        tick();
        chk_ra = 8'h05;
        #1;
        checkOutput("t6_mem", {32'h0, regmem[8'h05]}, 64'hAA22CC44);
        checkOutput("t6_hz", {63'h0, chk_hazard}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
